// File: rtl/key_entry_buffer_if.sv
// key_entry_buffer_if: keypad, tick and button inputs plus entry buffer outputs
interface key_entry_buffer_if;
  logic [3:0] key;
  logic       one_second;
  logic       alarm_button;
  logic       time_button;
  logic [3:0] key_ms_hr;
  logic [3:0] key_ls_hr;
  logic [3:0] key_ms_min;
  logic [3:0] key_ls_min;
  logic [2:0] digit_count;
  logic       show_keys;
  logic       load_alarm;
  logic       load_new_time;
  logic       entry_error;
  logic       entry_timeout;
  modport master (
    output key, one_second, alarm_button, time_button,
    input  key_ms_hr, key_ls_hr, key_ms_min, key_ls_min, digit_count,
           show_keys, load_alarm, load_new_time, entry_error, entry_timeout
  );
  modport slave (
    input  key, one_second, alarm_button, time_button,
    output key_ms_hr, key_ls_hr, key_ms_min, key_ls_min, digit_count,
           show_keys, load_alarm, load_new_time, entry_error, entry_timeout
  );
endinterface

// File: rtl/key_entry_buffer.sv
// key_entry_buffer: four-digit keypad entry with 24h check, load strobes and idle timeout; KEY_BACKSPACE_EN adds backspace on key 4'hC
module key_entry_buffer #(
  parameter int unsigned TIMEOUT_SEC = 10,
  parameter logic [3:0]  NOKEY       = 4'hA
) (
  input logic               clock,
  input logic               reset,
  key_entry_buffer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ENTRY, READY} state_t;
  state_t     r_state;
  logic [3:0] r_key_prev;
  logic       r_alarm_d;
  logic       r_time_d;
  logic [3:0] r_d3, r_d2, r_d1, r_d0;
  logic [2:0] r_count;
  logic [7:0] r_timer;
  logic       r_show;
  logic       r_load_alarm;
  logic       r_load_time;
  logic       r_error;
  logic       r_timeout;
  logic       w_press;
  logic       w_alarm_edge;
  logic       w_time_edge;
  logic       w_btn;
  logic       w_valid;
  logic       w_expire;
  assign w_press      = bus.key <= 4'd9 && r_key_prev == NOKEY;
  assign w_alarm_edge = bus.alarm_button && !r_alarm_d;
  assign w_time_edge  = bus.time_button && !r_time_d;
  assign w_btn        = w_alarm_edge || w_time_edge;
  assign w_valid      = r_d3 <= 4'd2 && !(r_d3 == 4'd2 && r_d2 > 4'd3) && r_d1 <= 4'd5;
  assign w_expire     = r_timer + 8'd1 == 8'(TIMEOUT_SEC);
`ifdef KEY_BACKSPACE_EN
  logic w_bksp;
  assign w_bksp = bus.key == 4'hC && r_key_prev == NOKEY;
`endif
  // Entry FSM: button edges take priority over presses, presses over the idle tick
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_key_prev   <= NOKEY;
      r_alarm_d    <= 1'b0;
      r_time_d     <= 1'b0;
      {r_d3, r_d2, r_d1, r_d0} <= 16'd0;
      r_count      <= 3'd0;
      r_timer      <= 8'd0;
      r_show       <= 1'b0;
      r_load_alarm <= 1'b0;
      r_load_time  <= 1'b0;
      r_error      <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_key_prev   <= bus.key;
      r_alarm_d    <= bus.alarm_button;
      r_time_d     <= bus.time_button;
      r_load_alarm <= 1'b0;
      r_load_time  <= 1'b0;
      r_error      <= 1'b0;
      r_timeout    <= 1'b0;
      if (r_state == IDLE) begin
        r_timer <= 8'd0;
        if (w_btn) begin
          r_error <= 1'b1;
        end else if (w_press) begin
          {r_d3, r_d2, r_d1, r_d0} <= {12'd0, bus.key};
          r_count <= 3'd1;
          r_state <= ENTRY;
          r_show  <= 1'b1;
        end
      end else if (w_btn) begin
        r_state <= IDLE;
        r_show  <= 1'b0;
        r_count <= 3'd0;
        r_timer <= 8'd0;
        if (r_state == READY && !(w_alarm_edge && w_time_edge) && w_valid) begin
          r_load_alarm <= w_alarm_edge;
          r_load_time  <= w_time_edge;
        end else begin
          r_error <= 1'b1;
          {r_d3, r_d2, r_d1, r_d0} <= 16'd0;
        end
      end else if (w_press) begin
        {r_d3, r_d2, r_d1, r_d0} <= {r_d2, r_d1, r_d0, bus.key};
        r_count <= r_count == 3'd4 ? 3'd4 : r_count + 3'd1;
        r_state <= r_count >= 3'd3 ? READY : ENTRY;
        r_timer <= 8'd0;
      end
`ifdef KEY_BACKSPACE_EN
      else if (w_bksp) begin
        {r_d3, r_d2, r_d1, r_d0} <= {4'd0, r_d3, r_d2, r_d1};
        r_count <= r_count - 3'd1;
        r_state <= r_count == 3'd1 ? IDLE : ENTRY;
        r_show  <= r_count != 3'd1;
        r_timer <= 8'd0;
      end
`endif
      else if (bus.one_second) begin
        if (w_expire) begin
          r_timeout <= 1'b1;
          {r_d3, r_d2, r_d1, r_d0} <= 16'd0;
          r_count <= 3'd0;
          r_timer <= 8'd0;
          r_state <= IDLE;
          r_show  <= 1'b0;
        end else begin
          r_timer <= r_timer + 8'd1;
        end
      end
    end
  end
  assign bus.key_ms_hr     = r_d3;
  assign bus.key_ls_hr     = r_d2;
  assign bus.key_ms_min    = r_d1;
  assign bus.key_ls_min    = r_d0;
  assign bus.digit_count   = r_count;
  assign bus.show_keys     = r_show;
  assign bus.load_alarm    = r_load_alarm;
  assign bus.load_new_time = r_load_time;
  assign bus.entry_error   = r_error;
  assign bus.entry_timeout = r_timeout;
endmodule

// File: tb/tb_key_entry_buffer.sv
// tb_key_entry_buffer: scoreboard bench; stimulus queues expected strobes/snapshots, monitor compares
module tb_key_entry_buffer;
  localparam logic [3:0] NOKEY = 4'hA;
  localparam logic [2:0] K_SNAP = 3'd0, K_ALARM = 3'd1, K_TIME = 3'd2, K_ERR = 3'd3, K_TO = 3'd4;
  typedef struct packed {
    logic [2:0]  kind;
    logic [15:0] d;
    logic [2:0]  c;
    logic        s;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic snap_req = 1'b0;
  int tests = 0;
  int fails = 0;
  exp_t q[$];
  key_entry_buffer_if bus();
  key_entry_buffer #(.TIMEOUT_SEC(3), .NOKEY(NOKEY)) dut (.clock(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic expect_ev(input logic [2:0] k, input logic [15:0] d, input logic [2:0] c, input logic s);
    q.push_back('{kind: k, d: d, c: c, s: s});
  endtask
  task automatic snap(input logic [15:0] d, input logic [2:0] c, input logic s);
    expect_ev(K_SNAP, d, c, s);
    snap_req = 1'b1;
    step(1);
    snap_req = 1'b0;
  endtask
  task automatic press(input logic [3:0] k);
    bus.key = k;
    step(1);
    bus.key = NOKEY;
    step(1);
  endtask
  task automatic button(input logic a, input logic t);
    bus.alarm_button = a;
    bus.time_button = t;
    step(1);
    bus.alarm_button = 1'b0;
    bus.time_button = 1'b0;
    step(1);
  endtask
  task automatic tick();
    bus.one_second = 1'b1;
    step(1);
    bus.one_second = 1'b0;
    step(1);
  endtask
  // Monitor: every strobe or snapshot request pops one expectation
  always @(negedge clk) begin
    logic [2:0] k;
    logic [15:0] d;
    int n;
    exp_t e;
    if (!rst) begin
      n = int'(bus.load_alarm) + int'(bus.load_new_time) + int'(bus.entry_error) + int'(bus.entry_timeout);
      k = bus.load_alarm ? K_ALARM : bus.load_new_time ? K_TIME : bus.entry_error ? K_ERR : bus.entry_timeout ? K_TO : K_SNAP;
      d = {bus.key_ms_hr, bus.key_ls_hr, bus.key_ms_min, bus.key_ls_min};
      if (n > 1) begin
        tests++;
        fails++;
        $display("FAIL multi_strobe: %0d strobes at once, required at most 1", n);
      end
      if (n > 0 || snap_req) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event: kind %0d seen, none expected", k);
        end else begin
          e = q.pop_front();
          if (k != e.kind) begin
            fails++;
            $display("FAIL event_kind: got %0d, required %0d", k, e.kind);
          end
          tests++;
          if (d != e.d || bus.digit_count != e.c || bus.show_keys != e.s) begin
            fails++;
            $display("FAIL state(kind %0d): got digits %h count %0d show %0b, required digits %h count %0d show %0b",
                     e.kind, d, bus.digit_count, bus.show_keys, e.d, e.c, e.s);
          end
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.key = NOKEY;
    bus.one_second = 1'b0;
    bus.alarm_button = 1'b0;
    bus.time_button = 1'b0;
    step(2);
    rst = 1'b0;
    snap(16'h0000, 3'd0, 1'b0);
    press(4'd1); press(4'd2); press(4'd3); press(4'd0);
    snap(16'h1230, 3'd4, 1'b1);
    expect_ev(K_ALARM, 16'h1230, 3'd0, 1'b0);
    button(1'b1, 1'b0);
    snap(16'h1230, 3'd0, 1'b0);
    press(4'd2); press(4'd5); press(4'd0); press(4'd0);
    expect_ev(K_ERR, 16'h0000, 3'd0, 1'b0);
    button(1'b0, 1'b1);
    snap(16'h0000, 3'd0, 1'b0);
    bus.key = 4'd7;
    step(20);
    bus.key = NOKEY;
    step(1);
    snap(16'h0007, 3'd1, 1'b1);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
    snap(16'h2345, 3'd4, 1'b1);
    expect_ev(K_TIME, 16'h2345, 3'd0, 1'b0);
    button(1'b0, 1'b1);
    press(4'd0); press(4'd9);
    snap(16'h0009, 3'd2, 1'b1);
    tick(); tick();
    expect_ev(K_TO, 16'h0000, 3'd0, 1'b0);
    tick();
    snap(16'h0000, 3'd0, 1'b0);
    press(4'd0); press(4'd9);
    tick(); tick();
    bus.key = 4'd5;
    bus.one_second = 1'b1;
    step(1);
    bus.key = NOKEY;
    bus.one_second = 1'b0;
    step(1);
    snap(16'h0095, 3'd3, 1'b1);
    expect_ev(K_ERR, 16'h0000, 3'd0, 1'b0);
    button(1'b1, 1'b0);
    press(4'd0); press(4'd8); press(4'd4); press(4'd5);
    snap(16'h0845, 3'd4, 1'b1);
    expect_ev(K_ERR, 16'h0000, 3'd0, 1'b0);
    button(1'b1, 1'b1);
    expect_ev(K_ERR, 16'h0000, 3'd0, 1'b0);
    button(1'b1, 1'b0);
    press(4'd1); press(4'd2);
    expect_ev(K_ERR, 16'h0000, 3'd0, 1'b0);
    bus.key = 4'd3;
    button(1'b1, 1'b0);
    bus.key = NOKEY;
    step(1);
    snap(16'h0000, 3'd0, 1'b0);
    press(4'd2); press(4'd3); press(4'd5); press(4'd9);
    expect_ev(K_ALARM, 16'h2359, 3'd0, 1'b0);
    button(1'b1, 1'b0);
    press(4'd1); press(4'd9); press(4'd6); press(4'd0);
    expect_ev(K_ERR, 16'h0000, 3'd0, 1'b0);
    button(1'b1, 1'b0);
    press(4'd4); press(4'd2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    snap(16'h0000, 3'd0, 1'b0);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
`ifdef KEY_BACKSPACE_EN
    press(4'hC);
    snap(16'h0123, 3'd3, 1'b1);
    press(4'hC); press(4'hC); press(4'hC);
    snap(16'h0000, 3'd0, 1'b0);
`else
    press(4'hC);
    snap(16'h1234, 3'd4, 1'b1);
    expect_ev(K_TIME, 16'h1234, 3'd0, 1'b0);
    button(1'b0, 1'b1);
`endif
    step(3);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/key_entry_buffer.md
Name: key_entry_buffer

Overview:
- Input-side counterpart of the four-digit display driver: collects keypad digits into a four-digit BCD entry buffer and presents them as key_ms_hr..key_ls_min.
- show_keys tells the display to show the buffer while entry is in progress.
- Checks the entered value against 24-hour format, then issues one-cycle load strobes to the alarm register or the time counter.
- Abandons an entry after a programmable number of idle seconds.

Parameters:
- TIMEOUT_SEC, 10, whole one_second pulses with no key press before an open entry is abandoned (1..255).
- NOKEY, 4'hA, keypad code meaning "no key held".

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- key  input  4  keypad code: 0-9 are digits; NOKEY means idle; other codes are ignored unless the optional feature is enabled.
- one_second  input  1  single-cycle tick, once per second.
- alarm_button  input  1  level; its rising edge requests an alarm-time load.
- time_button  input  1  level; its rising edge requests a current-time load.
- key_ms_hr, key_ls_hr, key_ms_min, key_ls_min  output  4 each  buffer digits, BCD.
- digit_count  output  3  digits entered, saturates at 4.
- show_keys  output  1  high in ENTRY or READY.
- load_alarm  output  1  one-cycle strobe; buffer holds a valid alarm time.
- load_new_time  output  1  one-cycle strobe; buffer holds a valid current time.
- entry_error  output  1  one-cycle strobe; rejected commit.
- entry_timeout  output  1  one-cycle strobe; entry abandoned.

Behaviour:
- Reset, when reset is high at a clock edge: state IDLE; all buffer digits 0; digit_count 0; all strobes 0; timeout counter 0; key and button history registers set to NOKEY/0.
- Press detection: a press is registered on the first cycle key is in 0-9 after the previous cycle's key was NOKEY. Holding a key gives one press. A digit-to-digit change without passing through NOKEY is not a press.
- Button detection: rising edge only, from a one-cycle-delayed copy of the button.
- Shift: a press shifts the buffer left:
  - ms_hr <= ls_hr, ls_hr <= ms_min, ms_min <= ls_min, ls_min <= digit.
  - Effect is registered, one cycle after the press cycle.
- State IDLE:
  - On a press, clear the buffer, then load it with {0,0,0,d}; digit_count becomes 1; go to ENTRY.
  - Button edges in IDLE produce entry_error.
- State ENTRY:
  - Each press shifts and increments digit_count.
  - When digit_count reaches 4, go to READY.
  - A button edge in ENTRY produces entry_error, clears the buffer and count, and returns to IDLE.
- State READY:
  - A further press shifts; digit_count stays 4 (last four digits kept).
  - A button edge runs the validity check: ms_hr<=2; if ms_hr==2 then ls_hr<=3; ms_min<=5.
  - Pass: pulse load_alarm (alarm_button) or load_new_time (time_button) for one cycle.
  - Fail: pulse entry_error.
  - Either way, go to IDLE and clear digit_count. The buffer keeps its value on pass, so the loading register samples it the same cycle as the strobe and one cycle after. The buffer clears on fail.
- Simultaneous events:
  - Both button edges in the same cycle give entry_error, with no load.
  - A button edge and a key press in the same cycle: the button wins and the press is discarded.
  - reset overrides everything.
- Timeout:
  - In ENTRY or READY the counter increments on each one_second and clears on each press.
  - When it would reach TIMEOUT_SEC, pulse entry_timeout, clear the buffer and count, and go to IDLE.
  - A press in the same cycle as the expiring tick cancels the timeout.
  - The counter holds 0 in IDLE.
- show_keys is a registered state decode, with no combinational path from key.

Optional Feature:
- Macro KEY_BACKSPACE_EN.
- When defined, key code 4'hC (edge-detected like a digit) is a backspace:
  - Shifts the buffer right: ls_min <= ms_min, ms_min <= ls_hr, ls_hr <= ms_hr, ms_hr <= 0.
  - Decrements digit_count and restarts the timeout counter.
  - READY goes to ENTRY.
  - If digit_count becomes 0, go to IDLE.
  - In IDLE, backspace is ignored.
- When not defined, 4'hC is ignored like any other non-digit code.

Test Plan:
- Reset check: after reset, press 1,2,3,0 each separated by NOKEY, then an alarm_button edge -> digits read 1,2,3,0; digit_count 4; show_keys high before the edge; load_alarm high exactly one cycle; state IDLE; show_keys low.
- Invalid time: enter 2,5,0,0, then a time_button edge -> entry_error one cycle; no load_new_time; buffer 0,0,0,0.
- Held key and overflow: hold key 7 for 20 cycles -> one press, digit_count 1. Then enter 1,2,3,4,5 -> buffer 2,3,4,5; count stays 4.
- Timeout: with TIMEOUT_SEC=3, enter 0,9 and apply 3 one_second ticks -> entry_timeout on the 3rd tick; show_keys low; buffer cleared. Repeat with a press on the 3rd tick -> no timeout.
- Same-cycle buttons: in READY with 0,8,4,5, raise both buttons in the same cycle -> entry_error; no load strobe. Also assert reset mid-entry -> all outputs 0 next cycle.
- Backspace (KEY_BACKSPACE_EN defined): enter 1,2,3,4 then 4'hC -> buffer 0,1,2,3; count 3; state ENTRY.
